// File: rtl/power_unit.sv
// ---------------------------------------------------------------------------
// power_unit
//
// Iterative unsigned power engine: result = num**exp mod 2**WIDTH.
// A single WIDTH x WIDTH multiplier is reused once per cycle. Only one
// operation is in flight at a time.
//
// Ports
//   clock      in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset (wins over handshakes)
//   in_valid   in   1      operand present
//   in_ready   out  1      engine idle and able to accept an operand
//   num        in   WIDTH  base, unsigned (sampled on accept)
//   exp        in   EXP_W  exponent, unsigned (sampled on accept)
//   out_valid  out  1      result present
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  low WIDTH bits of num**exp
//   overflow   out  1      true power did not fit in WIDTH bits
//
// Latency: accept in cycle C gives out_valid in cycle C + max(1, exp).
// result/overflow hold their last value after the output transfer.
// ---------------------------------------------------------------------------
module power_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned EXP_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num,
    input  logic [EXP_W-1:0] exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] ONE_EXP = {{(EXP_W-1){1'b0}}, 1'b1};

    state_t             state_q;
    logic [WIDTH-1:0]   acc_q;        // running partial power
    logic [WIDTH-1:0]   num_q;        // captured base
    logic [EXP_W-1:0]   cnt_q;        // multiplies still to perform
    logic               ovf_q;        // sticky overflow for the current operation
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               overflow_q;

    logic [2*WIDTH-1:0] full_prod;
    logic               prod_hi;

    // Full-width product so bits lost by truncation can be flagged.
    assign full_prod = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, num_q};
    assign prod_hi   = |full_prod[2*WIDTH-1:WIDTH];

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // in_ready is implied here: IDLE and not in reset.
                    if (in_valid) begin
                        num_q      <= num;
                        ovf_q      <= 1'b0;
                        overflow_q <= 1'b0;
                        if (exp == '0) begin
                            acc_q       <= ONE_W;
                            cnt_q       <= '0;
                            result_q    <= ONE_W;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else if (exp == ONE_EXP) begin
                            acc_q       <= num;
                            cnt_q       <= '0;
                            result_q    <= num;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            acc_q   <= num;
                            cnt_q   <= exp - ONE_EXP;
                            state_q <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    acc_q <= full_prod[WIDTH-1:0];
                    cnt_q <= cnt_q - ONE_EXP;
                    ovf_q <= ovf_q | prod_hi;
                    // Last multiply: publish straight from the product so the
                    // result is registered in the same cycle DONE is entered.
                    if (cnt_q == ONE_EXP) begin
                        result_q    <= full_prod[WIDTH-1:0];
                        overflow_q  <= ovf_q | prod_hi;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_power_unit.sv
// ---------------------------------------------------------------------------
// tb_power_unit
//
// Scoreboard bench for power_unit. Accepted operands are turned into expected
// responses by a wide-integer reference model and queued; a monitor checks
// latency, value, stability under back-pressure and handshake rules whenever
// the DUT presents a result.
// ---------------------------------------------------------------------------
module tb_power_unit;

    localparam int unsigned W  = 32;
    localparam int unsigned EW = 2;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        int unsigned  lat;
        int unsigned  cyc;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  num = '0;
    logic [EW-1:0] exp = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          overflow;

    int unsigned   n_cmp  = 0;
    int unsigned   n_fail = 0;
    int unsigned   cyc    = 0;
    bit            prev_ov = 1'b0;
    bit            rand_ready = 1'b0;
    exp_t          sb[$];

    power_unit #(.WIDTH(W), .EXP_W(EW)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .exp       (exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Reference: exact power in 128 bits (enough for (2**32-1)**3).
    function automatic exp_t model(input logic [W-1:0] n, input int unsigned e, input int unsigned c);
        exp_t         r;
        logic [127:0] p;
        p = 128'd1;
        for (int unsigned k = 0; k < e; k++) p = p * {96'd0, n};
        r.res = p[W-1:0];
        r.ovf = |p[127:W];
        r.lat = (e == 0) ? 1 : e;
        r.cyc = c;
        return r;
    endfunction

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard producer and response monitor.
    always @(negedge clock) begin
        if (reset) begin
            prev_ov = 1'b0;
            chk("in_ready_in_reset", {{W{1'b0}}, in_ready}, '0);
        end else begin
            if (in_valid && in_ready)
                sb.push_back(model(num, int'(exp), cyc));
            if (out_valid) begin
                chk("in_ready_while_out_valid", {{W{1'b0}}, in_ready}, '0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: result 0x%0h with no pending operation (cycle %0d)", result, cyc);
                end else begin
                    if (!prev_ov)
                        chk("latency", (W+1)'(cyc - sb[0].cyc), (W+1)'(sb[0].lat));
                    chk("result", {1'b0, result}, {1'b0, sb[0].res});
                    chk("overflow", {{W{1'b0}}, overflow}, {{W{1'b0}}, sb[0].ovf});
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_ov = out_valid;
        end
    end

    // Random back-pressure, only when enabled.
    always @(posedge clock) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        sb.delete();
        @(negedge clock);
        chk("in_ready_reset_hi", {{W{1'b0}}, in_ready}, '0);
        @(posedge clock);
        @(negedge clock);
        chk("reset_out_valid", {{W{1'b0}}, out_valid}, '0);
        chk("reset_result", {1'b0, result}, '0);
        chk("reset_overflow", {{W{1'b0}}, overflow}, '0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("in_ready_after_reset", {{W{1'b0}}, in_ready}, (W+1)'(1));
    endtask

    // Present an operand until accepted; optionally keep in_valid high after.
    task automatic send(input logic [W-1:0] n, input logic [EW-1:0] e, input bit hold);
        int unsigned t;
        bit          ok;
        bit          done;
        t = 0;
        done = 1'b0;
        in_valid = 1'b1;
        num = n;
        exp = e;
        while (!done) begin
            @(negedge clock);
            ok = in_ready && !reset;
            @(posedge clock); #1;
            if (ok) done = 1'b1;
            else if (++t > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: num 0x%0h exp %0d never accepted", n, e);
                done = 1'b1;
            end
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clock);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses pending, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [W-1:0] rn;
        // 1: reset, then 2**3
        do_reset();
        out_ready = 1'b1;
        send(32'd2, 2'd3, 1'b0);
        drain();

        // 2: exponent 0 and 1
        send(32'd5, 2'd0, 1'b0);
        send(32'd7, 2'd1, 1'b0);
        drain();

        // 3: overflow, then a clean op clears it
        send(32'h0001_0000, 2'd3, 1'b0);
        send(32'd3, 2'd2, 1'b0);
        drain();

        // 4: held result under back-pressure, new operand ignored
        out_ready = 1'b0;
        send(32'd4, 2'd3, 1'b0);
        in_valid = 1'b1;
        num = 32'd9;
        exp = 2'd1;
        repeat (8) @(posedge clock);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("t4_out_valid_drop", {{W{1'b0}}, out_valid}, '0);
        chk("t4_in_ready_back", {{W{1'b0}}, in_ready}, (W+1)'(1));
        drain();

        // 5: reset in the 2nd BUSY cycle discards the op
        send(32'd3, 2'd3, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t5_no_out_valid", {{W{1'b0}}, out_valid}, '0);
        end
        send(32'd4, 2'd3, 1'b0);
        drain();

        // 6: back-to-back stream with in_valid held
        send(32'd2, 2'd3, 1'b1);
        send(32'd3, 2'd3, 1'b1);
        send(32'd4, 2'd3, 1'b1);
        send(32'd5, 2'd3, 1'b0);
        drain();

        // Random operands, exponents, gaps and back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 4))
                0: rn = W'($urandom_range(0, 1));
                1: rn = W'($urandom_range(0, 15));
                2: rn = 32'h0001_0000 - 32'd2 + W'($urandom_range(0, 4));
                default: rn = $urandom;
            endcase
            send(rn, EW'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clock);
                #1;
            end
        end
        in_valid = 1'b0;
        @(posedge clock);
        rand_ready = 1'b0;
        #2;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
